// File: rtl/wb_stage_pkg.sv
// Shared pipeline constants for the write-back stage: source-select codes,
// load sizes and the bit layout of the WB_control bundle.
package wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_SRC_ALU  = 2'b00,
      WB_SRC_MEM  = 2'b01,
      WB_SRC_LINK = 2'b10,
      WB_SRC_RSVD = 2'b11
   } wb_src_e;

   typedef enum logic [1:0] {
      LS_BYTE     = 2'b00,
      LS_HALF     = 2'b01,
      LS_WORD     = 2'b10,
      LS_WORD_ALT = 2'b11
   } load_size_e;

   localparam int WBC_REG_WRITE     = 0;
   localparam int WBC_SRC_LSB       = 1;
   localparam int WBC_SRC_MSB       = 2;
   localparam int WBC_LOAD_UNSIGNED = 3;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle: MEM-stage inputs, pipeline control and the committed
// register-file write. master drives the MEM side, slave is the WB stage.
interface wb_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic                  stall;
   logic                  flush;
   logic                  in_valid;
   logic [3:0]            WB_control;
   logic [1:0]            load_size;
   logic [1:0]            addr_lo;
   logic [REG_ADDR_W-1:0] rd;
   logic [DATA_W-1:0]     data_from_mem;
   logic [DATA_W-1:0]     data_from_ALU;
   logic [DATA_W-1:0]     pc_plus8;
   logic                  reg_we;
   logic [REG_ADDR_W-1:0] reg_waddr;
   logic [DATA_W-1:0]     bus_w;
   logic                  wb_valid;
   logic [CNT_W-1:0]      retired_cnt;

   modport master (
      output stall, flush, in_valid, WB_control, load_size, addr_lo, rd,
             data_from_mem, data_from_ALU, pc_plus8,
      input  reg_we, reg_waddr, bus_w, wb_valid, retired_cnt
   );

   modport slave (
      input  stall, flush, in_valid, WB_control, load_size, addr_lo, rd,
             data_from_mem, data_from_ALU, pc_plus8,
      output reg_we, reg_waddr, bus_w, wb_valid, retired_cnt
   );
endinterface

// File: rtl/wb_stage_load_extract.sv
// Combinational sub-word load extraction: picks the byte/halfword lane for
// the configured endianness and sign- or zero-extends it to 32 bits.
module load_extract
   import wb_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        load_size,
   input  logic              load_unsigned,
   output logic [DATA_W-1:0] result
);

   logic [1:0] byte_lane;
   logic       half_sel;
   logic [7:0] byte_val;
   logic [15:0] half_val;

   // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
   always_comb begin
      byte_lane = BIG_ENDIAN ? (2'd3 - addr_lo) : addr_lo;
      half_sel  = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
      byte_val  = data[{byte_lane, 3'b000} +: 8];
      half_val  = data[{half_sel, 4'b0000} +: 16];
      result    = data;
      case (load_size_e'(load_size))
         LS_BYTE: result = {{(DATA_W-8){~load_unsigned & byte_val[7]}}, byte_val};
         LS_HALF: result = {{(DATA_W-16){~load_unsigned & half_val[15]}}, half_val};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, drives the
// register-file write port and counts retired register writes.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int CNT_W      = 32
) (
   input  logic   clk,
   input  logic   reset,
   wb_stage_if.slave wb
);

   wb_src_e               src;
   logic                  next_we;
   logic [DATA_W-1:0]     load_val;
   logic [DATA_W-1:0]     next_bus;

   logic                  valid_q;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0]     bus_q;
   logic [CNT_W-1:0]      cnt_q;

   load_extract #(
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_load_extract (
      .data          (wb.data_from_mem),
      .addr_lo       (wb.addr_lo),
      .load_size     (wb.load_size),
      .load_unsigned (wb.WB_control[WBC_LOAD_UNSIGNED]),
      .result        (load_val)
   );

   // The reserved source code falls through to the ALU result.
   always_comb begin
      src      = wb_src_e'(wb.WB_control[WBC_SRC_MSB:WBC_SRC_LSB]);
      next_we  = wb.in_valid & wb.WB_control[WBC_REG_WRITE] & (wb.rd != '0);
      next_bus = wb.data_from_ALU;
      case (src)
         WB_SRC_MEM:  next_bus = load_val;
         WB_SRC_LINK: next_bus = wb.pc_plus8;
         default:     next_bus = wb.data_from_ALU;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         bus_q   <= '0;
         cnt_q   <= '0;
      end else if (wb.flush) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
      end else if (!wb.stall) begin
         valid_q <= wb.in_valid;
         we_q    <= next_we;
         waddr_q <= wb.rd;
         bus_q   <= next_bus;
         if (next_we) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign wb.wb_valid    = valid_q;
   assign wb.reg_we      = we_q;
   assign wb.reg_waddr   = waddr_q;
   assign wb.bus_w       = bus_q;
   assign wb.retired_cnt = cnt_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised write-back stage for the MIPS/DLX pipeline. It holds the MEM/WB pipeline register and selects the register-file write value from three sources: ALU result, memory data or link address. It extracts and sign- or zero-extends byte and halfword loads, and handles pipeline stall and flush. It also presents the committed write (enable, address, data) to the register file and the forwarding unit, and counts retired register writes.

## Interface
- `DATA_W`, 32: datapath width. Must be 32; the byte/halfword lane logic is defined for 32 bits.
- `REG_ADDR_W`, 5: register address width.
- `BIG_ENDIAN`, 1: byte-lane order for sub-word loads. 1 = big-endian, 0 = little-endian.
- `CNT_W`, 32: width of the retired-write counter.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hold the pipeline register.
- `flush` in 1: invalidate the instruction being captured.
- `in_valid` in 1: a valid instruction is present at the MEM stage.
- `WB_control` in 4:
  - [0] reg_write.
  - [2:1] source select: 00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU).
  - [3] load_unsigned.
- `load_size` in 2: 00 byte, 01 half, 10 word, 11 word.
- `addr_lo` in 2: low address bits of the load.
- `rd` in REG_ADDR_W: destination register.
- `data_from_mem` in DATA_W: aligned memory word.
- `data_from_ALU` in DATA_W: ALU result.
- `pc_plus8` in DATA_W: link address.
- `reg_we` out 1: register-file write enable.
- `reg_waddr` out REG_ADDR_W: register-file write address.
- `bus_w` out DATA_W: register-file write data.
- `wb_valid` out 1: the WB slot holds a valid instruction.
- `retired_cnt` out CNT_W: number of committed register writes.

## Operation
- **Capture.** Each rising edge, the pipeline register updates by priority:
  1. `reset`: `wb_valid`=0, `reg_we`=0, `reg_waddr`=0, `bus_w`=0, `retired_cnt`=0.
  2. `flush`: `wb_valid`=0, `reg_we`=0. `bus_w` and `reg_waddr` keep their previous values.
  3. `stall`: all registers hold. `reg_we` is re-asserted only if it was already set. The register file tolerates an identical rewrite.
  4. Otherwise: capture `in_valid` into `wb_valid` and compute the outputs below.
- **Write enable.** `reg_we` = `in_valid` & reg_write & (`rd` != 0). A write to r0 is always suppressed, but `wb_valid` still follows `in_valid`.
- **Source select.**
  - ALU → `data_from_ALU`.
  - LINK → `pc_plus8`.
  - MEM → extracted load value:
    - Byte lane k = `addr_lo` when `BIG_ENDIAN`=0; k = 3−`addr_lo` when `BIG_ENDIAN`=1. Lane k occupies bits [8k+7:8k].
    - Half: `addr_lo[1]` selects the half (same endianness rule). `addr_lo[0]` is ignored; misalignment is trapped upstream.
    - Extension: zero-extend when load_unsigned=1, sign-extend otherwise.
    - Word: `data_from_mem` passes through unchanged.
- **Counter.** `retired_cnt` increments by 1 on each edge where a new capture sets `reg_we`=1, i.e. not during stall or flush. It wraps modulo 2^CNT_W with no saturation.
- **Priority corner cases.**
  - `flush` and `stall` together: flush wins.
  - `reset` together with anything: reset wins.

## Timing
- Latency is exactly 1 cycle from MEM-stage inputs to the `reg_we`/`reg_waddr`/`bus_w` outputs. All outputs are registers; there is no combinational input-to-output path.
- The register file writes on the same edge that a new value is captured. Same-cycle read of the written value requires the register file's write-first behaviour.
- The outputs feed the forwarding unit directly as the WB forwarding source.
- `retired_cnt` updates on the same edge as `reg_we` goes high for that instruction.
- Reset taken mid-stall discards the held instruction. The first capture after reset deassertion occurs on the following edge.

## Structure
- Shared pipeline package holds:
  - source-select constants `WB_SRC_ALU`/`WB_SRC_MEM`/`WB_SRC_LINK`;
  - load-size constants `LS_BYTE`/`LS_HALF`/`LS_WORD`;
  - bit positions of the `WB_control` fields.
- One sub-module, `load_extract`: purely combinational lane select and extension, parametrised by `BIG_ENDIAN`. It can be unit-tested separately.
- The 3:1 source multiplexer and all registers live in `wb_stage`.

## Test plan
- **ALU write.** reg_write=1, src=ALU, `rd`=5, `data_from_ALU`=0x12345678 → next cycle `reg_we`=1, `reg_waddr`=5, `bus_w`=0x12345678, `retired_cnt`=1.
- **Signed byte load, big-endian.** mem=0x80FF7F01, `addr_lo`=0, signed → `bus_w`=0xFFFFFF80. Same with `addr_lo`=3 and unsigned → 0x00000001.
- **Halfword load, little-endian build.** mem=0x8001ABCD, `addr_lo`=2, signed → `bus_w`=0xFFFF8001. With `addr_lo`=0, unsigned → 0x0000ABCD.
- **r0 and link.**
  - `rd`=0 with reg_write=1 → `reg_we`=0, `wb_valid`=1, counter unchanged.
  - src=LINK, `pc_plus8`=0x00400010, `rd`=31 → `bus_w`=0x00400010.
- **Stall/flush priority.** Hold `stall` for 3 cycles while inputs change → outputs constant and counter constant. Then assert `flush` and `stall` together → `wb_valid`=0, `reg_we`=0.
- **Reset mid-operation and wrap.**
  - Synchronous `reset` during a stream of writes → all outputs 0 on the next edge.
  - With `CNT_W`=4, 17 writes → `retired_cnt`=1.
